// File: rtl/ir_pkg.sv
`default_nettype none
// ir_pkg: shared types and constants for the IR line-error front end.
// Rev 1.0
package ir_pkg;

  typedef enum logic [2:0] {
    SETTLE = 3'd0,
    CNV_L  = 3'd1,
    WAIT_L = 3'd2,
    CNV_R  = 3'd3,
    WAIT_R = 3'd4,
    UPDATE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    INNER = 2'd0,
    MID   = 2'd1,
    OUTER = 2'd2
  } pair_t;

  localparam logic [2:0] CH_LEFT  [3] = '{3'd0, 3'd2, 3'd4};
  localparam logic [2:0] CH_RIGHT [3] = '{3'd1, 3'd3, 3'd5};

  localparam logic [1:0] SHIFT_INNER = 2'd0;
  localparam logic [1:0] SHIFT_MID   = 2'd1;
  localparam logic [1:0] SHIFT_OUTER = 2'd2;

  function automatic logic [2:0] left_ch(pair_t p);
    case (p)
      MID:     left_ch = CH_LEFT[1];
      OUTER:   left_ch = CH_LEFT[2];
      default: left_ch = CH_LEFT[0];
    endcase
  endfunction

  function automatic logic [2:0] right_ch(pair_t p);
    case (p)
      MID:     right_ch = CH_RIGHT[1];
      OUTER:   right_ch = CH_RIGHT[2];
      default: right_ch = CH_RIGHT[0];
    endcase
  endfunction

  function automatic logic [1:0] weight_shift(pair_t p);
    case (p)
      MID:     weight_shift = SHIFT_MID;
      OUTER:   weight_shift = SHIFT_OUTER;
      default: weight_shift = SHIFT_INNER;
    endcase
  endfunction

  function automatic pair_t next_pair(pair_t p);
    case (p)
      INNER:   next_pair = MID;
      MID:     next_pair = OUTER;
      default: next_pair = INNER;
    endcase
  endfunction

  // Bit 0 = inner, bit 1 = mid, bit 2 = outer.
  function automatic logic [2:0] pair_onehot(pair_t p);
    case (p)
      MID:     pair_onehot = 3'b010;
      OUTER:   pair_onehot = 3'b100;
      default: pair_onehot = 3'b001;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_settle_timer.sv
`default_nettype none
// ir_settle_timer: clear/enable counter; done flags the last settle clock.
// Rev 1.0
module ir_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [15:0] LAST = 16'(SETTLE_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (en && !done) begin
      count <= count + 16'd1;
    end
  end

  assign done = en && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/ir_err_compute.sv
`default_nettype none
// ir_err_compute: sequences three IR pairs through the A2D, produces weighted error.
// Optional IR_ERR_FILTER_EN: averages each new error with the previous one. Rev 1.0
module ir_err_compute
  import ir_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter logic [14:0] LINE_THRES    = 15'h0040
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic [2:0]  chnnl,
  output logic        strt_cnv,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [15:0] error,
  output logic        err_vld,
  output logic        line_present
);

  state_t state, state_nxt;
  pair_t  pair,  pair_nxt;

  logic settle_clr;
  logic settle_en;
  logic settle_done;

  logic               sample;
  logic        [15:0] weighted;
  logic signed [15:0] acc_err, acc_err_nxt;
  logic        [14:0] acc_sum, acc_sum_nxt;
  logic        [15:0] error_nxt;
  logic        [2:0]  en_q, en_nxt;

  assign settle_en  = (state == SETTLE);
  assign settle_clr = !settle_en;

  ir_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (settle_clr),
    .en    (settle_en),
    .done  (settle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SETTLE;
      pair  <= INNER;
    end else begin
      state <= state_nxt;
      pair  <= pair_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pair_nxt  = pair;
    case (state)
      SETTLE: if (settle_done) state_nxt = CNV_L;
      CNV_L:  state_nxt = WAIT_L;
      WAIT_L: if (cnv_cmplt) state_nxt = CNV_R;
      CNV_R:  state_nxt = WAIT_R;
      WAIT_R: begin
        if (cnv_cmplt) begin
          if (pair == OUTER) begin
            state_nxt = UPDATE;
          end else begin
            state_nxt = SETTLE;
            pair_nxt  = next_pair(pair);
          end
        end
      end
      UPDATE: begin
        state_nxt = SETTLE;
        pair_nxt  = INNER;
      end
      default: begin
        state_nxt = SETTLE;
        pair_nxt  = INNER;
      end
    endcase
  end

  // A result only counts while waiting on our own conversion.
  assign sample   = cnv_cmplt && ((state == WAIT_L) || (state == WAIT_R));
  assign weighted = {4'b0000, res} << weight_shift(pair);

  always_comb begin
    acc_err_nxt = acc_err;
    acc_sum_nxt = acc_sum;
    if (sample) begin
      if (state == WAIT_L) begin
        acc_err_nxt = acc_err - $signed(weighted);
      end else begin
        acc_err_nxt = acc_err + $signed(weighted);
      end
      acc_sum_nxt = acc_sum + {3'b000, res};
    end
  end

`ifdef IR_ERR_FILTER_EN
  logic signed [16:0] filt_sum;
  assign filt_sum  = $signed({acc_err_nxt[15], acc_err_nxt}) + $signed({error[15], error});
  assign error_nxt = 16'(filt_sum >>> 1);
`else
  assign error_nxt = acc_err_nxt;
`endif

  // Enables follow the next state so a pair hand-off needs no gap cycle.
  assign en_nxt = (state_nxt == UPDATE) ? 3'b000 : pair_onehot(pair_nxt);

  // Outputs are loaded on the edge entering UPDATE, so they are valid with err_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_err      <= 16'sd0;
      acc_sum      <= 15'd0;
      error        <= 16'd0;
      line_present <= 1'b0;
      err_vld      <= 1'b0;
      chnnl        <= 3'd0;
      en_q         <= 3'b000;
    end else begin
      err_vld <= (state_nxt == UPDATE);
      en_q    <= en_nxt;
      if (state_nxt == UPDATE) begin
        error        <= error_nxt;
        line_present <= (acc_sum_nxt >= LINE_THRES);
        acc_err      <= 16'sd0;
        acc_sum      <= 15'd0;
      end else begin
        acc_err <= acc_err_nxt;
        acc_sum <= acc_sum_nxt;
      end
      if (state_nxt == CNV_L) begin
        chnnl <= left_ch(pair_nxt);
      end else if (state_nxt == CNV_R) begin
        chnnl <= right_ch(pair_nxt);
      end
    end
  end

  assign strt_cnv  = (state == CNV_L) || (state == CNV_R);
  assign IR_in_en  = en_q[0];
  assign IR_mid_en = en_q[1];
  assign IR_out_en = en_q[2];

endmodule
`default_nettype wire

// File: tb/tb_ir_err_compute.sv
`default_nettype none
// tb_ir_err_compute: directed vectors, scoreboard queue, protocol monitor.
// Rev 1.0
module tb_ir_err_compute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IR_in_en, IR_mid_en, IR_out_en;
  logic [2:0]  chnnl;
  logic        strt_cnv;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [15:0] error;
  logic        err_vld;
  logic        line_present;

  ir_err_compute #(
    .SETTLE_CYCLES(8),
    .LINE_THRES   (15'h0040)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IR_in_en     (IR_in_en),
    .IR_mid_en    (IR_mid_en),
    .IR_out_en    (IR_out_en),
    .chnnl        (chnnl),
    .strt_cnv     (strt_cnv),
    .cnv_cmplt    (cnv_cmplt),
    .res          (res),
    .error        (error),
    .err_vld      (err_vld),
    .line_present (line_present)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] err;
    logic        lp;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [11:0] tbl [6];
  logic [11:0] vt  [9][6];
  logic [15:0] vraw[9];
  logic        vlp [9];
  logic [15:0] prev_f;

  int tmo_req    = 0;
  int stray_req  = 0;
  int fin_req    = 0;

  // A2D model: result arrives 5 cycles after strt_cnv.
  int a2d_cnt;
  int a2d_ch;
  int stray_done;
  always @(negedge clk) begin
    if (!rst_n) begin
      a2d_cnt    = 0;
      cnv_cmplt  = 1'b0;
      res        = 12'd0;
      stray_done = stray_req;
    end else begin
      cnv_cmplt = 1'b0;
      if (a2d_cnt > 0) begin
        a2d_cnt--;
        if (a2d_cnt == 0) begin
          cnv_cmplt = 1'b1;
          res       = tbl[a2d_ch];
        end
      end else if (stray_req != stray_done) begin
        stray_done++;
        cnv_cmplt = 1'b1;
        res       = 12'hFFF;
      end
      if (strt_cnv) begin
        a2d_cnt = 5;
        a2d_ch  = int'(chnnl);
      end
    end
  end

  // Monitor: owns every comparison and both counters.
  int       cyc = 0;
  int       exp_ch;
  int       rise_cyc;
  int       last_vld;
  int       rel_cyc;
  bit       have_last, armed, first_after_rst, in_rst;
  logic     prev_vld;
  logic [2:0] prev_en, en;
  int       tmo_seen = 0;
  bit       fin_done = 0;
  exp_t     e;
  always @(negedge clk) begin
    cyc++;
    if (tmo_req != tmo_seen) begin
      tmo_seen = tmo_req;
      checks++; errors++;
      $display("FAIL timeout: err_vld not seen within bound (got none, want pulse)");
    end
    if (fin_req != 0 && !fin_done) begin
      fin_done = 1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
      end
    end
    if (!rst_n) begin
      in_rst = 1; exp_ch = 0; armed = 0; have_last = 0; prev_vld = 0; prev_en = 3'b000;
      checks++;
      if ({IR_in_en, IR_mid_en, IR_out_en, chnnl, strt_cnv, err_vld, line_present, error} !== 25'd0) begin
        errors++;
        $display("FAIL reset_outs: got en=%b ch=%0d strt=%b vld=%b lp=%b err=%h, want all 0",
                 {IR_out_en, IR_mid_en, IR_in_en}, chnnl, strt_cnv, err_vld, line_present, error);
      end
    end else begin
      if (in_rst) begin
        in_rst = 0; rel_cyc = cyc; first_after_rst = 1;
      end
      en = {IR_out_en, IR_mid_en, IR_in_en};
      checks++;
      if (!$onehot0(en)) begin
        errors++;
        $display("FAIL en_onehot: got %b, want one-hot or zero", en);
      end
      if (en != 3'b000 && en != prev_en) rise_cyc = cyc;
      if (strt_cnv) begin
        checks++;
        if (int'(chnnl) != exp_ch) begin
          errors++;
          $display("FAIL chnnl_seq: got %0d, want %0d", chnnl, exp_ch);
        end
        exp_ch = (exp_ch == 5) ? 0 : exp_ch + 1;
        if (armed && !chnnl[0]) begin
          checks++;
          if (cyc - rise_cyc != 8) begin
            errors++;
            $display("FAIL settle_time: got %0d clocks, want 8", cyc - rise_cyc);
          end
        end
      end
      if (err_vld) begin
        checks++;
        if (prev_vld) begin
          errors++;
          $display("FAIL vld_width: got high 2+ cycles, want 1");
        end
        if (have_last) begin
          checks++;
          if (cyc - last_vld != 61) begin
            errors++;
            $display("FAIL period: got %0d, want 61", cyc - last_vld);
          end
        end
        // Reset released just before cycle 0; err_vld lands in cycle 60 (the 61st clock).
        if (first_after_rst) begin
          checks++;
          if (cyc - rel_cyc != 60) begin
            errors++;
            $display("FAIL first_latency: got %0d, want 60", cyc - rel_cyc);
          end
          first_after_rst = 0;
        end
        have_last = 1; last_vld = cyc; armed = 1;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_vld: got err=%h, want no pulse", error);
        end else begin
          e = sb.pop_front();
          checks++;
          if (error !== e.err) begin
            errors++;
            $display("FAIL error_val: got %h, want %h", error, e.err);
          end
          checks++;
          if (line_present !== e.lp) begin
            errors++;
            $display("FAIL line_present: got %b, want %b", line_present, e.lp);
          end
        end
      end
      prev_vld = err_vld;
      prev_en  = en;
    end
  end

  task automatic load(input int i, input logic [11:0] c0, c1, c2, c3, c4, c5,
                      input logic [15:0] raw, input logic lp);
    vt[i][0] = c0; vt[i][1] = c1; vt[i][2] = c2;
    vt[i][3] = c3; vt[i][4] = c4; vt[i][5] = c5;
    vraw[i] = raw; vlp[i] = lp;
  endtask

  // Apply vector v to the A2D table and queue its expected result.
  task automatic apply(input int v);
    exp_t x;
    logic signed [16:0] s;
    for (int c = 0; c < 6; c++) tbl[c] = vt[v][c];
    x.err = vraw[v];
`ifdef IR_ERR_FILTER_EN
    s     = $signed({vraw[v][15], vraw[v]}) + $signed({prev_f[15], prev_f});
    x.err = 16'(s >>> 1);
`else
    s     = 17'sd0;
`endif
    prev_f = x.err;
    x.lp   = vlp[v];
    sb.push_back(x);
  endtask

  task automatic wait_vld();
    bit seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (err_vld) seen = 1;
    end
    if (!seen) tmo_req++;
  endtask

  task automatic wait_high(input bit which);
    bit seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (which ? strt_cnv : IR_mid_en) seen = 1;
    end
    if (!seen) tmo_req++;
  endtask

  initial begin
    rst_n  = 1'b0;
    prev_f = 16'd0;
    load(0, 12'h800, 12'h900, 12'h800, 12'h800, 12'h800, 12'h800, 16'h0100, 1'b1);
    load(1, 12'h800, 12'h900, 12'h800, 12'h800, 12'h800, 12'h800, 16'h0100, 1'b1);
    load(2, 12'h800, 12'h900, 12'h800, 12'h800, 12'h800, 12'h800, 16'h0100, 1'b1);
    load(3, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 16'h0000, 1'b1);
    load(4, 12'h800, 12'h800, 12'h800, 12'h900, 12'h800, 12'h800, 16'h0200, 1'b1);
    load(5, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h900, 16'h0400, 1'b1);
    load(6, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000, 16'hC004, 1'b1);
    load(7, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 16'h0000, 1'b0);
    load(8, 12'h800, 12'h800, 12'h800, 12'h900, 12'h800, 12'h800, 16'h0200, 1'b1);

    apply(0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 1; v < 8; v++) begin
      wait_vld();
      apply(v);
      if (v == 1) begin
        // Stray completion in the middle of the mid pair's settle window.
        wait_high(1'b0);
        repeat (3) @(negedge clk);
        stray_req++;
      end
    end
    wait_vld();

    // Interrupt mid-pair WAIT_L; the loop in flight has no expectation queued.
    for (int c = 0; c < 6; c++) tbl[c] = vt[8][c];
    wait_high(1'b0);
    wait_high(1'b1);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    prev_f = 16'd0;
    apply(8);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_vld();

    repeat (2) @(negedge clk);
    fin_req = 1;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ir_err_compute.md
Name: ir_err_compute

Overview:
Upstream stage of the PID block. Sequences three IR emitter/receiver pairs (inner, mid, outer) through the shared A2D. Computes a signed, weighted left/right imbalance and a line-present flag. Presents error[15:0], err_vld and line_present directly to the PID controller.

Parameters:
SETTLE_CYCLES, 4096, clocks an emitter pair is enabled before its first conversion starts; legal range 2..65535.
LINE_THRES, 15'h0040, minimum sum of all six readings for line_present=1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
IR_in_en  out  1  inner emitter pair enable
IR_mid_en  out  1  mid emitter pair enable
IR_out_en  out  1  outer emitter pair enable
chnnl  out  3  A2D channel select
strt_cnv  out  1  one-cycle A2D start pulse
cnv_cmplt  in  1  one-cycle A2D done pulse; res valid that cycle
res  in  12  unsigned A2D result
error  out  16  signed weighted error, right minus left
err_vld  out  1  one-cycle pulse: error and line_present just updated
line_present  out  1  registered line-detect flag

Behaviour:
- Reset: all outputs 0, including error, err_vld, line_present, all IR_*_en, strt_cnv and chnnl. FSM goes to SETTLE with pair=inner, accumulators cleared.
- Free-running after reset; no enable input.
- Pair to channel mapping (left, right): inner (0, 1), mid (2, 3), outer (4, 5). Weights: inner x1, mid x2, outer x4, applied by left shift.
- FSM states: SETTLE -> CNV_L -> WAIT_L -> CNV_R -> WAIT_R -> (next pair SETTLE | UPDATE) -> SETTLE (inner).
- SETTLE:
  - Exactly one IR_*_en is high (one-hot for the current pair).
  - Settle counter clears on entry.
  - After SETTLE_CYCLES clocks in SETTLE, go to CNV_L.
- CNV_L / CNV_R:
  - Single cycle: strt_cnv=1, chnnl=left or right channel.
  - chnnl holds its value through the following WAIT state.
- WAIT_L / WAIT_R:
  - Hold until cnv_cmplt. In the cnv_cmplt cycle, capture res.
  - Accumulation: acc_err -= res<<w on left reads; acc_err += res<<w on right reads; acc_sum += res on every read.
  - cnv_cmplt outside WAIT states, or coincident with strt_cnv, is ignored.
- Emitter enable stays high through both conversions of its pair. It switches directly to the next pair's enable on leaving WAIT_R; there are no dead cycles with two enables high.
- UPDATE (single cycle):
  - error <= acc_err; line_present <= (acc_sum >= LINE_THRES); err_vld=1.
  - acc_err and acc_sum clear; all IR_*_en low for this one cycle.
  - err_vld is therefore high exactly one cycle, the cycle after the outer WAIT_R cnv_cmplt.
- Widths:
  - acc_err is 16-bit signed. Maximum magnitude 7*4095=28665, so no overflow and no saturation needed.
  - acc_sum is 15-bit unsigned (max 6*4095=24570).
- error and line_present hold between UPDATE cycles.
- No timeout: a missing cnv_cmplt stalls the FSM indefinitely, with err_vld staying 0.
- Reset mid-operation: immediate async return to reset values. No partial-cycle err_vld is ever produced.
- Loop period: 3*(SETTLE_CYCLES + 2 + 2*A2D latency) + 1 clocks.

Optional Feature:
IR_ERR_FILTER_EN:
- Defined: UPDATE writes error <= (acc_err + error_prev) >>> 1, using a 17-bit signed intermediate and an arithmetic shift. error_prev is the previous output error; it resets to 0.
- Undefined: error <= acc_err as above.
- line_present and err_vld timing are identical in both cases.

Decomposition:
- Package ir_pkg:
  - state enum (SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R, UPDATE);
  - pair enum (INNER, MID, OUTER);
  - localparam channel arrays for left/right;
  - weight shift constants 0/1/2.
- Sub-module ir_settle_timer: a clear/enable counter parameterised by SETTLE_CYCLES with a done output.

Test Plan:
(All tests: SETTLE_CYCLES=8; A2D model returns cnv_cmplt 5 cycles after strt_cnv.)
1. All channels return res=12'h800 -> error=16'h0000, line_present=1, err_vld high exactly 1 cycle per loop, period = 3*(8+2+10)+1 = 61 clocks.
2. ch1=12'h900, all others 12'h800 -> error=16'h0100; with ch3=12'h900 instead -> 16'h0200; with ch5 -> 16'h0400.
3. ch4=12'hFFF, all others 0 -> error=16'hC004, line_present=1; then all channels 0 -> error=0, line_present=0.
4. Protocol monitor:
   - chnnl sequence is 0,1,2,3,4,5 repeating;
   - IR_*_en always one-hot or zero;
   - each pair's first strt_cnv comes exactly 8 clocks after its enable rises;
   - a stray cnv_cmplt injected during SETTLE is ignored and the accumulated result is unchanged.
5. Assert rst_n low during mid-pair WAIT_L -> all outputs 0 immediately. After release, chnnl restarts at 0 and the first err_vld appears 61 clocks later with correct values.
6. With IR_ERR_FILTER_EN, from reset with the step-2 stimulus (raw 16'h0100) -> first error=16'h0080, second 16'h00C0, third 16'h00E0.
